wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- MIPS write-back stage. It is the writer side of the register-file write port and drives `reg_write`/`waddr`/`wdata` into the register file.
- Accepts retired instructions from MEM through a valid/ready handshake.
- For loads, waits for the data-memory response, then extracts and extends the addressed byte or halfword.
- Exports the pending-load destination so the decode-stage hazard logic can stall dependent reads.

Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum number of `S_WAIT` cycles before an outstanding load is abandoned (legal range ≥2).
- `TO_W`, default 5: width of the timeout counter. Must satisfy 2^`TO_W` > `TIMEOUT_CYCLES`.

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset, synchronous, active-low
- `mem_valid`  in  1  MEM presents an instruction
- `mem_ready`  out  1  wb_stage can accept (combinational: 1 iff state == `S_IDLE`)
- `mem_reg_write`  in  1  instruction writes a GPR
- `mem_waddr`  in  5  destination register
- `mem_result`  in  32  ALU/move result (non-load)
- `mem_is_load`  in  1  instruction is a load
- `mem_load_type`  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW; other codes behave as LW
- `mem_addr_lo`  in  2  effective address bits [1:0]
- `dmem_rvalid`  in  1  load data valid (single-cycle pulse)
- `dmem_rdata`  in  32  load data word, little-endian lanes
- `reg_write`  out  1  register-file write enable
- `waddr`  out  5  register-file write address
- `wdata`  out  32  register-file write data
- `pending_valid`  out  1  load outstanding (state == `S_WAIT` and captured reg_write = 1 and captured waddr ≠ 0)
- `pending_waddr`  out  5  destination of the outstanding load
- `load_err`  out  1  one-cycle pulse: load timed out

Behaviour:

Reset (synchronous, `rstn` = 0 at a `clk` edge):
- state ← `S_IDLE`; `reg_write`, `waddr`, `wdata`, `load_err`, timeout counter and captured fields ← 0.
- Outputs: `pending_valid` = 0, `mem_ready` = 1 while `rstn` = 0.
- A reset during `S_WAIT` drops the load. Any later `dmem_rvalid` is ignored and produces no write.

Handshake:
- Transfer occurs on `mem_valid` && `mem_ready` at a rising edge.
- `mem_ready` is 0 throughout `S_WAIT`; MEM must hold its inputs stable.

Non-load transfer (`mem_is_load` = 0):
- Next cycle: `reg_write` = `mem_reg_write` && (`mem_waddr` ≠ 0), `waddr` = `mem_waddr`, `wdata` = `mem_result`.
- Latency is 1 cycle. Back-to-back transfers are allowed every cycle.

Load transfer (`mem_is_load` = 1):
- Capture `mem_reg_write`, `mem_waddr`, `mem_load_type` and `mem_addr_lo`; go to `S_WAIT`; clear the counter.
- `reg_write` = 0 for the next cycle.
- This applies even when `mem_reg_write` = 0: the state still enters `S_WAIT` to consume the response, and the final `reg_write` stays 0.

`S_WAIT`:
- When `dmem_rvalid` = 1: extract data, register `reg_write`/`waddr`/`wdata` for exactly one cycle on the following cycle, return to `S_IDLE`. `mem_ready` = 1 in that following cycle.
- Otherwise the counter increments.
- If the counter == `TIMEOUT_CYCLES`-1 with no `dmem_rvalid`: next cycle `load_err` = 1 for one cycle, `reg_write` = 0, state ← `S_IDLE`.
- `S_WAIT` therefore lasts at most `TIMEOUT_CYCLES` cycles.
- `dmem_rvalid` arriving in the same edge as the timeout takes priority: the write happens and no error is raised.

Extraction:
- Byte b = `dmem_rdata`[8*`addr_lo` +: 8].
- Halfword h = `addr_lo`[1] ? `dmem_rdata`[31:16] : `dmem_rdata`[15:0].
- LB: sign-extend b. LBU: zero-extend b. LH: sign-extend h. LHU: zero-extend h. LW: full word.
- Misalignment is not checked here; it is excepted upstream.

Other rules:
- `dmem_rvalid` in `S_IDLE` is ignored (no write, no error).
- `reg_write` is never asserted for `waddr` = 0.
- Outputs are registered. `reg_write` is a single-cycle pulse per instruction; `waddr`/`wdata` hold their last value when `reg_write` = 0.

Test Plan:
1. ALU write: after reset, present `mem_valid`=1, `mem_reg_write`=1, `mem_waddr`=5, `mem_result`=0xDEADBEEF for 1 cycle → next cycle `reg_write`=1, `waddr`=5, `wdata`=0xDEADBEEF. The cycle after, `reg_write`=0. Then 3 back-to-back ALU ops → 3 consecutive write pulses.
2. LB: load type 000, `addr_lo`=3, `waddr`=9; `dmem_rvalid` 2 cycles after accept with rdata 0x80FF1234 → `mem_ready`=0 and `pending_valid`=1, `pending_waddr`=9 during wait. Cycle after rvalid: `reg_write`=1, `waddr`=9, `wdata`=0xFFFFFF80.
3. Halfword: rdata 0x80017FFF, `addr_lo`=2. LHU → 0x00008001; LH → 0xFFFF8001; LH with `addr_lo`=0 → 0x00007FFF. LBU `addr_lo`=1 → 0x0000007F.
4. Zero register: ALU op and LW with `waddr`=0 → `reg_write` stays 0; LW still waits for and consumes rvalid; `pending_valid`=0.
5. Timeout: LW with no rvalid → `mem_ready`=0 for exactly 16 cycles, then `load_err`=1 for one cycle, no write, `mem_ready`=1. A late rvalid afterwards is ignored. Rvalid on the 16th wait cycle → write occurs, `load_err`=0.
6. Reset mid-wait: LW accepted, `rstn`=0 for 1 cycle at wait cycle 2, rvalid at cycle 4 → no `reg_write` ever; all outputs 0 after reset; `mem_ready`=1.

Source files
------------

// File: rtl/wb_stage.sv
// MIPS write-back: registers the GPR write for ALU results (1 cycle) and for loads (1 cycle after dmem_rvalid).
// mem_ready drops while a load is outstanding; an unanswered load is abandoned after TIMEOUT_CYCLES with load_err.
module wb_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_result,
    input  logic        mem_is_load,
    input  logic [2:0]  mem_load_type,
    input  logic [1:0]  mem_addr_lo,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        reg_write,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        pending_valid,
    output logic [4:0]  pending_waddr,
    output logic        load_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              cap_we_q, cap_we_d;
    logic [4:0]        cap_waddr_q, cap_waddr_d;
    logic [2:0]        cap_type_q, cap_type_d;
    logic [1:0]        cap_lo_q, cap_lo_d;
    logic              reg_write_q, reg_write_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              load_err_q, load_err_d;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_data;

    always_comb begin
        byte_sel = 8'h00;
        case (cap_lo_q)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = cap_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (cap_type_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {24'h000000, byte_sel};
            3'b010:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b011:  load_data = {16'h0000, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_we_d    = cap_we_q;
        cap_waddr_d = cap_waddr_q;
        cap_type_d  = cap_type_q;
        cap_lo_d    = cap_lo_q;
        reg_write_d = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        load_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    if (mem_is_load) begin
                        cap_we_d    = mem_reg_write;
                        cap_waddr_d = mem_waddr;
                        cap_type_d  = mem_load_type;
                        cap_lo_d    = mem_addr_lo;
                        cnt_d       = '0;
                        state_d     = S_WAIT;
                    end else if (mem_reg_write && (mem_waddr != 5'd0)) begin
                        reg_write_d = 1'b1;
                        waddr_d     = mem_waddr;
                        wdata_d     = mem_result;
                    end
                end
            end
            S_WAIT: begin
                // A response on the timeout edge still wins over the error.
                if (dmem_rvalid) begin
                    state_d = S_IDLE;
                    if (cap_we_q && (cap_waddr_q != 5'd0)) begin
                        reg_write_d = 1'b1;
                        waddr_d     = cap_waddr_q;
                        wdata_d     = load_data;
                    end
                end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    load_err_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cap_we_q    <= 1'b0;
            cap_waddr_q <= 5'd0;
            cap_type_q  <= 3'd0;
            cap_lo_q    <= 2'd0;
            reg_write_q <= 1'b0;
            waddr_q     <= 5'd0;
            wdata_q     <= 32'd0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_we_q    <= cap_we_d;
            cap_waddr_q <= cap_waddr_d;
            cap_type_q  <= cap_type_d;
            cap_lo_q    <= cap_lo_d;
            reg_write_q <= reg_write_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            load_err_q  <= load_err_d;
        end
    end

    assign mem_ready     = (state_q == S_IDLE) || !rstn;
    assign pending_valid = rstn && (state_q == S_WAIT) && cap_we_q && (cap_waddr_q != 5'd0);
    assign pending_waddr = cap_waddr_q;
    assign reg_write     = reg_write_q;
    assign waddr         = waddr_q;
    assign wdata         = wdata_q;
    assign load_err      = load_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU writes, load extraction, zero register, timeout and reset mid-load.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_reg_write;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_result;
    logic        mem_is_load;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_addr_lo;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        reg_write;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        pending_valid;
    logic [4:0]  pending_waddr;
    logic        load_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    wb_stage #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
        .clk(clk), .rstn(rstn),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_reg_write(mem_reg_write), .mem_waddr(mem_waddr), .mem_result(mem_result),
        .mem_is_load(mem_is_load), .mem_load_type(mem_load_type), .mem_addr_lo(mem_addr_lo),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .reg_write(reg_write), .waddr(waddr), .wdata(wdata),
        .pending_valid(pending_valid), .pending_waddr(pending_waddr), .load_err(load_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic alu(input logic we, input logic [4:0] wa, input logic [31:0] res);
        mem_valid     = 1'b1;
        mem_is_load   = 1'b0;
        mem_reg_write = we;
        mem_waddr     = wa;
        mem_result    = res;
    endtask

    // Accepts a load, waits d cycles past the accept edge, then pulses dmem_rvalid.
    task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] lo,
                           input logic [4:0] wa, input logic we, input logic [31:0] rd, input int d);
        mem_valid     = 1'b1;
        mem_is_load   = 1'b1;
        mem_load_type = lt;
        mem_addr_lo   = lo;
        mem_waddr     = wa;
        mem_reg_write = we;
        tick();
        mem_valid = 1'b0;
        chk({tag, "_ready_wait"}, 32'(mem_ready), 32'd0);
        chk({tag, "_pend_vld"}, 32'(pending_valid), 32'((we && wa != 5'd0) ? 1 : 0));
        repeat (d) tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = rd;
        tick();
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        int n;
        rstn = 1'b0; mem_valid = 1'b0; mem_reg_write = 1'b0; mem_waddr = 5'd0;
        mem_result = 32'd0; mem_is_load = 1'b0; mem_load_type = 3'd0; mem_addr_lo = 2'd0;
        dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        tick();
        chk("rst_ready_low", 32'(mem_ready), 32'd1);
        tick();
        rstn = 1'b1;
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        chk("rst_pending", 32'(pending_valid), 32'd0);

        // ALU write and back-to-back ALU writes
        alu(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        mem_valid = 1'b0;
        chk("alu_we", 32'(reg_write), 32'd1);
        chk("alu_waddr", 32'(waddr), 32'd5);
        chk("alu_wdata", wdata, 32'hDEADBEEF);
        tick();
        chk("alu_pulse_end", 32'(reg_write), 32'd0);
        chk("alu_hold_wdata", wdata, 32'hDEADBEEF);
        alu(1'b1, 5'd1, 32'h11111111);
        tick();
        chk("b2b0_we", 32'(reg_write), 32'd1);
        chk("b2b0_wdata", wdata, 32'h11111111);
        alu(1'b1, 5'd2, 32'h22222222);
        tick();
        chk("b2b1_we", 32'(reg_write), 32'd1);
        chk("b2b1_waddr", 32'(waddr), 32'd2);
        alu(1'b1, 5'd31, 32'h33333333);
        tick();
        mem_valid = 1'b0;
        chk("b2b2_we", 32'(reg_write), 32'd1);
        chk("b2b2_wdata", wdata, 32'h33333333);
        tick();
        chk("b2b_end", 32'(reg_write), 32'd0);

        // LB with pending-destination export
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_load_type = 3'b000;
        mem_addr_lo = 2'd3; mem_waddr = 5'd9; mem_reg_write = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("lb_ready", 32'(mem_ready), 32'd0);
        chk("lb_pend_vld", 32'(pending_valid), 32'd1);
        chk("lb_pend_waddr", 32'(pending_waddr), 32'd9);
        chk("lb_no_early_we", 32'(reg_write), 32'd0);
        tick();
        chk("lb_pend_vld2", 32'(pending_valid), 32'd1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF1234;
        tick();
        dmem_rvalid = 1'b0;
        chk("lb_we", 32'(reg_write), 32'd1);
        chk("lb_waddr", 32'(waddr), 32'd9);
        chk("lb_wdata", wdata, 32'hFFFFFF80);
        chk("lb_ready_back", 32'(mem_ready), 32'd1);
        chk("lb_pend_clr", 32'(pending_valid), 32'd0);
        tick();
        chk("lb_pulse_end", 32'(reg_write), 32'd0);

        // Halfword / byte extraction
        do_load("lhu2", 3'b011, 2'd2, 5'd10, 1'b1, 32'h80017FFF, 0);
        chk("lhu2_wdata", wdata, 32'h00008001);
        do_load("lh2", 3'b010, 2'd2, 5'd11, 1'b1, 32'h80017FFF, 1);
        chk("lh2_wdata", wdata, 32'hFFFF8001);
        chk("lh2_waddr", 32'(waddr), 32'd11);
        do_load("lh0", 3'b010, 2'd0, 5'd12, 1'b1, 32'h80017FFF, 0);
        chk("lh0_wdata", wdata, 32'h00007FFF);
        do_load("lbu1", 3'b001, 2'd1, 5'd13, 1'b1, 32'h80017FFF, 2);
        chk("lbu1_wdata", wdata, 32'h0000007F);
        do_load("lt7", 3'b111, 2'd1, 5'd14, 1'b1, 32'hCAFEF00D, 0);
        chk("lt7_wdata", wdata, 32'hCAFEF00D);
        tick();

        // Zero register: no writes, load still consumes its response
        alu(1'b1, 5'd0, 32'h5A5A5A5A);
        tick();
        mem_valid = 1'b0;
        chk("r0_alu_we", 32'(reg_write), 32'd0);
        do_load("r0_lw", 3'b100, 2'd0, 5'd0, 1'b1, 32'h01020304, 1);
        chk("r0_lw_we", 32'(reg_write), 32'd0);
        chk("r0_lw_ready", 32'(mem_ready), 32'd1);
        do_load("nowe_lw", 3'b100, 2'd0, 5'd6, 1'b0, 32'h01020304, 0);
        chk("nowe_lw_we", 32'(reg_write), 32'd0);
        chk("nowe_lw_ready", 32'(mem_ready), 32'd1);

        // Timeout with no response
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_load_type = 3'b100;
        mem_addr_lo = 2'd0; mem_waddr = 5'd7; mem_reg_write = 1'b1;
        tick();
        mem_valid = 1'b0;
        n = 0;
        while (!mem_ready && n < 40) begin
            chk("to_no_err_early", 32'(load_err), 32'd0);
            n = n + 1;
            tick();
        end
        chk("to_wait_cycles", 32'(n), 32'd16);
        chk("to_err", 32'(load_err), 32'd1);
        chk("to_no_we", 32'(reg_write), 32'd0);
        chk("to_pend_clr", 32'(pending_valid), 32'd0);
        tick();
        chk("to_err_pulse", 32'(load_err), 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0BAD0;
        tick();
        dmem_rvalid = 1'b0;
        chk("late_rvalid_we", 32'(reg_write), 32'd0);
        chk("late_rvalid_err", 32'(load_err), 32'd0);

        // Response on the last wait cycle beats the timeout
        do_load("edge", 3'b100, 2'd0, 5'd7, 1'b1, 32'h12345678, 15);
        chk("edge_we", 32'(reg_write), 32'd1);
        chk("edge_wdata", wdata, 32'h12345678);
        chk("edge_err", 32'(load_err), 32'd0);
        tick();
        chk("edge_err_after", 32'(load_err), 32'd0);

        // Reset in the middle of a load
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_load_type = 3'b100;
        mem_addr_lo = 2'd0; mem_waddr = 5'd3; mem_reg_write = 1'b1;
        tick();
        mem_valid = 1'b0;
        tick();
        rstn = 1'b0;
        #1;
        chk("rstw_ready_comb", 32'(mem_ready), 32'd1);
        chk("rstw_pend_comb", 32'(pending_valid), 32'd0);
        tick();
        rstn = 1'b1;
        chk("rstw_we", 32'(reg_write), 32'd0);
        chk("rstw_waddr", 32'(waddr), 32'd0);
        chk("rstw_wdata", wdata, 32'd0);
        chk("rstw_err", 32'(load_err), 32'd0);
        chk("rstw_ready", 32'(mem_ready), 32'd1);
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFEEDFACE;
        tick();
        dmem_rvalid = 1'b0;
        chk("rstw_late_we", 32'(reg_write), 32'd0);
        chk("rstw_late_err", 32'(load_err), 32'd0);
        tick();
        chk("rstw_final_we", 32'(reg_write), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
